// File: rtl/pixel_mem_pkg.sv
// Shared constants and the read-response slot type for the pixel memory responder.
package pixel_mem_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned BE_W             = 4;
  localparam int unsigned MAX_READ_LATENCY = 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_slot_t;

endpackage

// File: rtl/pixel_mem_responder_read_resp_pipe.sv
// Fixed-length shift register for read responses; rst flushes every slot.
module read_resp_pipe
  import pixel_mem_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_slot_t slot_in,
  output rd_slot_t slot_out
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst;
    assign slot_out    = slot_in;
  end else begin : g_shift
    rd_slot_t stage [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
        stage[0] <= slot_in;
        for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
    end

    assign slot_out = stage[STAGES-1];
  end

endmodule

// File: rtl/pixel_mem_responder.sv
// Avalon-MM slave over a byte-enabled word memory with pipelined reads,
// periodic single-cycle back-pressure and a sticky read+write protocol flag.
module pixel_mem_responder
  import pixel_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STALL_EVERY  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  input  logic [BE_W-1:0]   slave_byteenable,
  output logic              slave_waitrequest,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic              protocol_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              wr_accept;
  logic              rd_accept;
  rd_slot_t          head;
  rd_slot_t          tail;

  assign accept    = (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_accept = accept & slave_write;
  // A simultaneous read+write is treated as a write only.
  assign rd_accept = accept & slave_read & ~slave_write;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      if (slave_byteenable[0]) mem[slave_address][7:0]   <= slave_writedata[7:0];
      if (slave_byteenable[1]) mem[slave_address][15:8]  <= slave_writedata[15:8];
      if (slave_byteenable[2]) mem[slave_address][23:16] <= slave_writedata[23:16];
      if (slave_byteenable[3]) mem[slave_address][31:24] <= slave_writedata[31:24];
    end
  end

  // First latency stage: the RAM output register itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
    end else begin
      head.valid <= rd_accept;
      if (rd_accept) head.data <= mem[slave_address];
    end
  end

  read_resp_pipe #(
    .STAGES(READ_LATENCY - 1)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .slot_in  (head),
    .slot_out (tail)
  );

  assign slave_readdatavalid = tail.valid;
  assign slave_readdata      = tail.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if (slave_read && slave_write) begin
      protocol_err <= 1'b1;
    end
  end

  if (STALL_EVERY == 0) begin : g_no_stall
    assign slave_waitrequest = 1'b0;
  end else begin : g_stall
    localparam int unsigned CNT_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    logic [CNT_W-1:0] count;
    logic             stall;

    // Stall is registered so waitrequest never depends combinationally on inputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        count <= '0;
        stall <= 1'b0;
      end else if (accept) begin
        if (count == CNT_W'(STALL_EVERY - 1)) begin
          count <= '0;
          stall <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
          stall <= 1'b0;
        end
      end else begin
        stall <= 1'b0;
      end
    end

    assign slave_waitrequest = stall;
  end

endmodule

// File: tb/tb_pixel_mem_responder.sv
// Scoreboard bench for pixel_mem_responder: two instances (no-stall/latency 2 and
// stall-every-3/latency 4) driven by directed and random traffic against a memory model.
module tb_pixel_mem_responder;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic        rd      [2];
  logic        wr      [2];
  logic [9:0]  addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic        waitreq [2];
  logic [31:0] rdata   [2];
  logic        rdv     [2];
  logic        perr    [2];

  always #5 clk = ~clk;

  pixel_mem_responder #(.ADDR_W(10), .READ_LATENCY(2), .STALL_EVERY(0)) dut_a (
    .clk(clk), .rst(rst[0]), .slave_address(addr[0]), .slave_read(rd[0]),
    .slave_write(wr[0]), .slave_writedata(wdata[0]), .slave_byteenable(be[0]),
    .slave_waitrequest(waitreq[0]), .slave_readdata(rdata[0]),
    .slave_readdatavalid(rdv[0]), .protocol_err(perr[0]));

  pixel_mem_responder #(.ADDR_W(10), .READ_LATENCY(4), .STALL_EVERY(3)) dut_b (
    .clk(clk), .rst(rst[1]), .slave_address(addr[1]), .slave_read(rd[1]),
    .slave_write(wr[1]), .slave_writedata(wdata[1]), .slave_byteenable(be[1]),
    .slave_waitrequest(waitreq[1]), .slave_readdata(rdata[1]),
    .slave_readdatavalid(rdv[1]), .protocol_err(perr[1]));

  // Reference model state
  logic [31:0] mdl [2][1024];
  int          lat      [2];
  int          k_stall  [2];
  int          acc_cnt  [2];
  int          stall_at [2];
  bit          perr_exp [2];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_exp(input int d, input logic [31:0] data, input int due);
    exp_t e;
    e.data = data;
    e.due  = due;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Monitor: every readdatavalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      if (rdv[d] === 1'b1) begin
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          n_checks++;
          $display("FAIL unexpected_rdv_dut%0d: readdatavalid=1 data=0x%08h, expected no response (cycle %0d)",
                   d, rdata[d], cyc);
        end else begin
          check($sformatf("rd_data_dut%0d", d), rdata[d], e.data);
          check($sformatf("rd_cycle_dut%0d", d), 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic idle(input int d, input int n);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int d);
    rd[d]  = 1'b0;
    wr[d]  = 1'b0;
    rst[d] = 1'b1;
    if (d == 0) q0.delete();
    else        q1.delete();
    acc_cnt[d]  = 0;
    stall_at[d] = -10;
    perr_exp[d] = 1'b0;
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
    check($sformatf("rst_rdv_dut%0d", d), 32'(rdv[d]), 32'd0);
    check($sformatf("rst_waitreq_dut%0d", d), 32'(waitreq[d]), 32'd0);
    check($sformatf("rst_rdata_dut%0d", d), rdata[d], 32'd0);
    check($sformatf("rst_perr_dut%0d", d), 32'(perr[d]), 32'd0);
  endtask

  // Presents one request and holds it until the model says it is accepted.
  task automatic req(input int d, input bit r, input bit w, input logic [9:0] a,
                     input logic [31:0] data, input logic [3:0] b, output int waits);
    bit          done;
    bit          stall_exp;
    logic [31:0] mask;
    done  = 1'b0;
    waits = 0;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = data; be[d] = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      stall_exp = (cyc == stall_at[d]);
      check($sformatf("waitreq_dut%0d", d), 32'(waitreq[d]), 32'(stall_exp));
      if (!stall_exp) begin
        if (w) begin
          mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
          mdl[d][a] = (mdl[d][a] & ~mask) | (data & mask);
          if (r) perr_exp[d] = 1'b1;
        end else begin
          push_exp(d, mdl[d][a], cyc + lat[d]);
        end
        if (k_stall[d] > 0) begin
          acc_cnt[d]++;
          if (acc_cnt[d] == k_stall[d]) begin
            acc_cnt[d]  = 0;
            stall_at[d] = cyc + 1;
          end
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL accept_timeout_dut%0d: request never accepted within 20 cycles", d);
    end
  endtask

  int          w;
  int          wsum;
  int          c0;
  int          op;
  logic [9:0]  ra;
  logic [31:0] rdat;
  logic [3:0]  rbe;

  initial begin
    lat[0] = 2; lat[1] = 4;
    k_stall[0] = 0; k_stall[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    do_reset(0);
    do_reset(1);

    // Preload addresses 0..63 with value = address on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) req(d, 1'b0, 1'b1, 10'(i), 32'(i), 4'hF, w);
      idle(d, 2);
    end

    // 16 back-to-back reads: responses on 16 consecutive cycles, in order.
    for (int i = 0; i < 16; i++) req(0, 1'b1, 1'b0, 10'(i), '0, '0, w);
    idle(0, 6);

    // Full write, partial byte write, then read back.
    req(0, 1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, w);
    req(0, 1'b0, 1'b1, 10'd5, 32'h000000AA, 4'h1, w);
    req(0, 1'b0, 1'b1, 10'd5, 32'hFFFFFFFF, 4'h0, w);
    req(0, 1'b1, 1'b0, 10'd5, '0, '0, w);
    idle(0, 4);

    // Write then read next cycle; read then write next cycle.
    req(0, 1'b0, 1'b1, 10'd2, 32'h11, 4'hF, w);
    req(0, 1'b1, 1'b0, 10'd2, '0, '0, w);
    req(0, 1'b1, 1'b0, 10'd3, '0, '0, w);
    req(0, 1'b0, 1'b1, 10'd3, 32'h22, 4'hF, w);
    req(0, 1'b1, 1'b0, 10'd3, '0, '0, w);
    idle(0, 4);

    // Read and write together: write only, no response, sticky error.
    req(0, 1'b1, 1'b1, 10'd9, 32'h12345678, 4'hF, w);
    check("perr_set", 32'(perr[0]), 32'd1);
    idle(0, 5);
    check("perr_held", 32'(perr[0]), 32'd1);
    req(0, 1'b1, 1'b0, 10'd9, '0, '0, w);
    idle(0, 4);

    // Stall pattern: 7 back-to-back writes take 9 cycles, stalls before 4th and 7th.
    idle(1, 8);
    do_reset(1);
    wsum = 0;
    c0   = cyc;
    for (int i = 0; i < 7; i++) begin
      req(1, 1'b0, 1'b1, 10'(100 + i), 32'hA000 + 32'(i), 4'hF, w);
      check($sformatf("stall_waits_w%0d", i), 32'(w), (i == 3 || i == 6) ? 32'd1 : 32'd0);
      wsum += w;
    end
    check("stall_total_cycles", 32'(cyc - c0), 32'd9);
    check("stall_total_waits", 32'(wsum), 32'd2);
    for (int i = 0; i < 7; i++) req(1, 1'b1, 1'b0, 10'(100 + i), '0, '0, w);
    idle(1, 10);

    // Reset with three reads in flight: all responses discarded, memory kept.
    do_reset(1);
    for (int i = 0; i < 3; i++) req(1, 1'b1, 1'b0, 10'(20 + i), '0, '0, w);
    do_reset(1);
    idle(1, 10);
    check("perr_after_rst", 32'(perr[1]), 32'd0);
    for (int i = 0; i < 3; i++) req(1, 1'b1, 1'b0, 10'(20 + i), '0, '0, w);
    idle(1, 8);

    // Random traffic against the model.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 250; n++) begin
        op   = $urandom_range(0, 19);
        ra   = 10'($urandom_range(0, 63));
        rdat = $urandom;
        rbe  = 4'($urandom);
        if (op < 8)       req(d, 1'b1, 1'b0, ra, '0, '0, w);
        else if (op < 15) req(d, 1'b0, 1'b1, ra, rdat, rbe, w);
        else if (op < 19) idle(d, $urandom_range(1, 3));
        else              req(d, 1'b1, 1'b1, ra, rdat, rbe, w);
      end
      idle(d, 1);
    end

    for (int i = 0; i < 30 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_dut0", 32'(q0.size()), 32'd0);
    check("drain_dut1", 32'(q1.size()), 32'd0);
    check("perr_final_dut0", 32'(perr[0]), 32'(perr_exp[0]));
    check("perr_final_dut1", 32'(perr[1]), 32'(perr_exp[1]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
